lz_restore: RTL and testbench
=============================

# lz_restore

Multi-cycle denormalizer that reverses leading-zero normalization in the pipeline datapath. It accepts a normalized 32-bit word (MSB set) and a leading-zero count 0..32, and shifts the word right by that count to rebuild the original operand, so the result has exactly `count` leading zeros. It sits beside the leading-zero counter in the EX stage. It is driven by a start/busy/done handshake that the pipeline control uses to stall while the block is busy.

## Interface
- `STEP`, default 8: maximum right-shift distance applied per SHIFT cycle. Legal values are 1, 2, 4, 8, 16, 32.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `start` input 1: request a new operation. Accepted only in IDLE.
- `data_in` input 32: normalized word. Sampled on the accepting edge.
- `count_in` input 6: leading-zero count. Sampled on the accepting edge.
- `busy` output 1: high in SHIFT and DONE.
- `done` output 1: high for exactly one cycle, in the DONE state.
- `result` output 32: restored word. Valid from DONE onward; held until the next accepted start or reset.
- `count_err` output 1: set when the accepted `count_in` > 32. Held with `result`.
- `norm_err` output 1: set when the accepted `data_in[31]` == 0 and the effective count < 32, meaning the input was not normalized. Held with `result`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If `start` is high, latch `data_in` into the working register, latch rem = min(`count_in`, 32), and latch both error flags.
  - Go to SHIFT if rem > 0, else go to DONE.
  - `start` is ignored when not high.
- **SHIFT**, each edge:
  - Working register shifts right logically by s = min(rem, STEP), zero-fill.
  - rem -= s.
  - When rem becomes 0, go to DONE.
- **DONE**: `done` is high. On the next edge go to IDLE. `result` keeps the working register value.
- `start` in SHIFT or DONE is ignored: not queued, not latched.
- `result` is driven directly from the working register.
  - In SHIFT it shows intermediate values, so consumers use it only when `done` is high or in IDLE after a completed operation.
  - On the accepting edge the working register loads the new `data_in`, so `result` changes then.
- Arithmetic:
  - Final `result` = `data_in` >> min(`count_in`, 32).
  - An effective count of 32 yields 32'h00000000.
  - No rotation and no sign extension.
- Errors do not abort the operation. The shift still completes with the clamped count.

## Timing
- The operation is accepted on edge T0, with `start` high in IDLE.
- Number of SHIFT cycles N = ceil(n/STEP), where n is the effective count. N = 0 when n = 0.
- `done` is high during the cycle after edge T0+N, i.e. latency N+1 cycles from the accepting edge.
- `busy` rises the cycle after T0 and falls together with `done`. Busy time is N+1 cycles.
- With STEP=8: n=0 gives 1 cycle, n=1..8 gives 2, n=32 gives 5. This is the worst case.
- Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after DONE. Throughput is 1 op per N+2 cycles.
- Reset: on any edge with `rst` high:
  - FSM goes to IDLE.
  - rem = 0.
  - `result` = 0, `busy` = 0, `done` = 0, `count_err` = 0, `norm_err` = 0.
- Reset mid-SHIFT aborts the operation. No `done` pulse is produced.
- Reset dominates `start` on the same edge.

## Test plan
- Reset state: hold `rst` 2 cycles with `start` high. Required: `busy`=0, `done`=0, `result`=0, both error flags 0; no operation accepted.
- Basic restore: `data_in`=32'h80000000, `count_in`=5. Required: `done` 2 cycles after accept, `result`=32'h04000000, errors 0.
- Boundary counts:
  - `count_in`=0 with 32'hDEADBEEF: `result`=32'hDEADBEEF after 1 cycle.
  - `count_in`=32 with 32'hFFFFFFFF: `result`=0 after 5 cycles, `busy` high exactly 5 cycles.
- Errors:
  - `count_in`=40 with 32'h80000000: `result`=0, `count_err`=1, latency 5.
  - `count_in`=3 with 32'h40000000: `result`=32'h08000000, `norm_err`=1.
- Handshake:
  - Pulse `start` during SHIFT and during DONE with different data: ignored, first result unchanged.
  - A `start` in the first IDLE cycle after DONE is accepted.
- Reset mid-op: `count_in`=32, assert `rst` on the 2nd SHIFT cycle. Required: no `done` pulse, `result`=0. A following op with `count_in`=8 on 32'hFF000000 gives 32'h00FF0000.

Source files
------------

// File: rtl/lz_restore.sv
// Multi-cycle denormalizer: shifts a normalized word right by its leading-zero
// count, at most STEP bit positions per cycle, under a start/busy/done handshake.
module lz_restore #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [5:0]  count_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        count_err,
    output logic        norm_err
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] work_reg;
    logic [5:0]  rem_reg;
    logic        count_err_reg;
    logic        norm_err_reg;

    logic [5:0]  eff_count;
    logic [5:0]  shift_amt;

    // Counts above 32 are clamped so the word simply shifts out to zero.
    assign eff_count = (count_in > 6'd32) ? 6'd32 : count_in;
    assign shift_amt = (rem_reg < STEP_W) ? rem_reg : STEP_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (eff_count != 6'd0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (rem_reg <= STEP_W) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Working register doubles as the result; error flags are held alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg      <= 32'd0;
            rem_reg       <= 6'd0;
            count_err_reg <= 1'b0;
            norm_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        work_reg      <= data_in;
                        rem_reg       <= eff_count;
                        count_err_reg <= (count_in > 6'd32);
                        norm_err_reg  <= ~data_in[31] && (eff_count < 6'd32);
                    end
                end
                ST_SHIFT: begin
                    work_reg <= work_reg >> shift_amt;
                    rem_reg  <= rem_reg - shift_amt;
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = work_reg;
    assign count_err = count_err_reg;
    assign norm_err  = norm_err_reg;

endmodule

// File: tb/tb_lz_restore.sv
// Scoreboard bench for lz_restore: stimulus queues expected results, a monitor
// checks each done pulse for value, error flags and busy duration.
module tb_lz_restore;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic [5:0]  count_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        count_err;
    logic        norm_err;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ce;
        logic        ne;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   busy_cnt = 0;

    lz_restore #(.STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .count_in  (count_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .count_err (count_err),
        .norm_err  (norm_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: busy time up to and including the done cycle is the latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got result %h expected no done", result);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".result"}, result, e.res);
                    chk({e.name, ".count_err"}, 32'(count_err), 32'(e.ce));
                    chk({e.name, ".norm_err"}, 32'(norm_err), 32'(e.ne));
                    chk({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic op(input string name, input logic [31:0] d, input logic [5:0] c,
                      input logic [31:0] r, input logic ce, input logic ne, input int lat);
        wait_idle();
        start    = 1'b1;
        data_in  = d;
        count_in = c;
        @(posedge clk);
        exp_q.push_back('{name, r, ce, ne, lat});
        #1 start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b1;
        data_in = 32'hDEADBEEF;
        count_in = 6'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.count_err", 32'(count_err), 32'd0);
        chk("reset.norm_err", 32'(norm_err), 32'd0);
        start = 1'b0;
        rst = 1'b0;

        op("basic",    32'h80000000, 6'd5,  32'h04000000, 1'b0, 1'b0, 2);
        op("count0",   32'hDEADBEEF, 6'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1);
        op("count32",  32'hFFFFFFFF, 6'd32, 32'h00000000, 1'b0, 1'b0, 5);
        op("count40",  32'h80000000, 6'd40, 32'h00000000, 1'b1, 1'b0, 5);
        op("unnorm",   32'h40000000, 6'd3,  32'h08000000, 1'b0, 1'b1, 2);
        wait_idle();
        @(negedge clk);
        chk("hold.result", result, 32'h08000000);
        chk("hold.norm_err", 32'(norm_err), 32'd1);

        // Start held high through SHIFT and DONE with foreign data, then
        // retargeted for the first IDLE cycle after DONE.
        op("hs_first", 32'h80000000, 6'd16, 32'h00008000, 1'b0, 1'b0, 3);
        start = 1'b1;
        data_in = 32'h12345678;
        count_in = 6'd4;
        repeat (3) @(posedge clk);
        #1 data_in = 32'hC0000000;
        count_in = 6'd9;
        @(posedge clk);
        exp_q.push_back('{"hs_second", 32'h00600000, 1'b0, 1'b0, 3});
        #1 start = 1'b0;

        // Reset on the second SHIFT cycle: no done pulse, result cleared.
        wait_idle();
        start = 1'b1;
        data_in = 32'h80000000;
        count_in = 6'd32;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.result", result, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort.done", 32'(done), 32'd0);

        op("after_rst", 32'hFF000000, 6'd8, 32'h00FF0000, 1'b0, 1'b0, 2);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
